// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for DIGITS common-anode digits
//             sharing one 4-bit-to-7-segment decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int DIV    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic                  lz_sup,
   output logic [3:0]            b,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DIV - 1);
   localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(DIGITS - 1);
   localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

   logic [c_CW-1:0]       r_cnt;
   logic [c_IW-1:0]       r_idx;
   logic [4*DIGITS-1:0]   r_shadow_data;
   logic [DIGITS-1:0]     r_shadow_mask;
   logic                  r_shadow_lz;
   logic                  r_frame;

   logic                  w_slot_end;
   logic                  w_frame_end;
   logic                  w_capture;
   logic [3:0]            w_nib [DIGITS];
   logic [DIGITS-1:0]     w_nib_zero;
   logic [DIGITS-1:0]     w_upper_zero;
   logic [DIGITS-1:0]     w_sel;
   logic                  w_lz_dark;
   logic                  w_dark;

   assign w_slot_end  = (r_cnt == c_CNT_LAST);
   assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
   assign w_capture   = en && w_frame_end;

   // Scan position, shadow registers and the frame pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shadow_data <= '0;
         r_shadow_mask <= '0;
         r_shadow_lz   <= 1'b0;
         r_frame       <= 1'b0;
      end else begin
         r_frame <= w_capture;
         if (en) begin
            if (w_slot_end) begin
               r_cnt <= '0;
               r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
            end else begin
               r_cnt <= r_cnt + c_CNT_ONE;
            end
         end
         if (w_capture) begin
            r_shadow_data <= data;
            r_shadow_mask <= blank_mask;
            r_shadow_lz   <= lz_sup;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_nib[gi]      = r_shadow_data[4*gi +: 4];
         assign w_nib_zero[gi] = (r_shadow_data[4*gi +: 4] == 4'd0);
         assign w_sel[gi]      = (r_idx == c_IW'(gi));
      end
   endgenerate

   // w_upper_zero[i]: every nibble from i up to the most significant is zero
   always_comb begin
      logic v_acc;
      v_acc        = 1'b1;
      w_upper_zero = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_acc           = v_acc & w_nib_zero[i];
         w_upper_zero[i] = v_acc;
      end
   end

   // Digit 0 is never suppressed so an all-zero value still shows one "0"
   assign w_lz_dark = r_shadow_lz && (r_idx != '0) && w_upper_zero[r_idx];

   assign w_dark = !en
                || (r_cnt == '0)
                || r_shadow_mask[r_idx]
                || w_lz_dark;

   assign b     = w_nib[r_idx];
   assign an    = w_dark ? {DIGITS{1'b1}} : ~w_sel;
   assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Scoreboard bench for seg_scan_ctrl (DIGITS=4, DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int DIV    = 4;

   typedef struct {
      logic [DIGITS-1:0] an;
      logic [3:0]        b;
      logic              fr;
   } exp_t;

   logic                clk;
   logic                rst;
   logic                en;
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   blank_mask;
   logic                lz_sup;
   logic [3:0]          b;
   logic [DIGITS-1:0]   an;
   logic                frame;

   int total = 0;
   int bad   = 0;
   int n_rel = 0;

   exp_t q[$];

   // reference model state
   int                  m_cnt   = 0;
   int                  m_idx   = 0;
   logic [4*DIGITS-1:0] m_sdata = '0;
   logic [DIGITS-1:0]   m_smask = '0;
   logic                m_slz   = 1'b0;
   logic                m_frame = 1'b0;

   seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .data       (data),
      .blank_mask (blank_mask),
      .lz_sup     (lz_sup),
      .b          (b),
      .an         (an),
      .frame      (frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model on the clock edge using the inputs the DUT sampled
   task automatic tick();
      bit cap;
      @(posedge clk);
      if (rst) begin
         m_cnt = 0; m_idx = 0; m_sdata = '0; m_smask = '0; m_slz = 1'b0; m_frame = 1'b0;
         n_rel = 0;
      end else begin
         n_rel++;
         cap = en && (m_cnt == DIV - 1) && (m_idx == DIGITS - 1);
         m_frame = cap;
         if (cap) begin
            m_sdata = data; m_smask = blank_mask; m_slz = lz_sup;
         end
         if (en) begin
            if (m_cnt == DIV - 1) begin
               m_cnt = 0;
               m_idx = (m_idx + 1) % DIGITS;
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   endtask

   // Drive the inputs for this cycle and push the outputs they should produce
   task automatic apply(input logic i_r, input logic i_e, input logic [15:0] i_d,
                        input logic [3:0] i_m, input logic i_l);
      exp_t e;
      bit   dark;
      #2;
      rst = i_r; en = i_e; data = i_d; blank_mask = i_m; lz_sup = i_l;
      dark = !en || (m_cnt == 0) || m_smask[m_idx]
          || (m_slz && (m_idx != 0) && ((m_sdata >> (4 * m_idx)) == 0));
      e.b  = m_sdata[4*m_idx +: 4];
      e.an = dark ? 4'b1111 : ~(4'b0001 << m_idx);
      e.fr = m_frame;
      q.push_back(e);
   endtask

   task automatic step(input logic i_r, input logic i_e, input logic [15:0] i_d,
                       input logic [3:0] i_m, input logic i_l);
      tick();
      apply(i_r, i_e, i_d, i_m, i_l);
   endtask

   // Monitor: pop one expectation per cycle and compare on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("an", 32'(an), 32'(e.an));
            check("b", 32'(b), 32'(e.b));
            check("frame", 32'(frame), 32'(e.fr));
         end
      end
   end

   task automatic do_reset(input logic [15:0] d);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, d, 4'b0000, 1'b0);
   endtask

   initial begin
      logic [3:0] e_an;
      int         slot;
      int         ph;
      int         held_cnt;
      int         held_idx;
      bit         dropped;

      rst = 1'b1; en = 1'b1; data = 16'hFFFF; blank_mask = '0; lz_sup = 1'b0;

      // reset held with en=1 and all-F data
      do_reset(16'hFFFF);
      #2;
      check("rst_an", 32'(an), 32'hF);
      check("rst_b", 32'(b), 32'h0);
      check("rst_frame", 32'(frame), 32'h0);

      // basic scan with literal expectations over the second frame
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
         if (n_rel >= 16 && n_rel <= 31) begin
            slot = (n_rel - 16) / 4;
            ph   = (n_rel - 16) % 4;
            e_an = (ph == 0) ? 4'b1111 : ~(4'b0001 << slot);
            #2;
            check("basic_an", 32'(an), 32'(e_an));
            check("basic_b", 32'(b), 32'(4 - slot));
            check("basic_frame", 32'(frame), (n_rel == 16) ? 32'h1 : 32'h0);
         end
      end

      // tear-free update: data changes in cycle 20
      do_reset(16'h1234);
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 1'b1, (n_rel >= 19) ? 16'hABCD : 16'h1234, 4'b0000, 1'b0);
         if (n_rel == 29) begin
            #2;
            check("tear_old_an", 32'(an), 32'h7);
            check("tear_old_b", 32'(b), 32'h1);
         end
         if (n_rel == 33) begin
            #2;
            check("tear_new_an", 32'(an), 32'hE);
            check("tear_new_b", 32'(b), 32'hD);
         end
      end

      // leading-zero suppression
      do_reset(16'h0050);
      for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b1);
      for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 16'h0000, 4'b0000, 1'b1);
      for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 16'h0050, 4'b0000, 1'b0);

      // blank mask, then en dropped for 5 cycles at cnt=2
      do_reset(16'h1234);
      for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
      dropped  = 1'b0;
      held_cnt = 0;
      held_idx = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!dropped && m_cnt == 2 && m_idx == 1) begin
            dropped  = 1'b1;
            held_cnt = m_cnt;
            held_idx = m_idx;
            apply(1'b0, 1'b0, 16'h1234, 4'b0100, 1'b0);
            for (int j = 0; j < 4; j++) step(1'b0, 1'b0, 16'h1234, 4'b0100, 1'b0);
            #2;
            check("hold_an", 32'(an), 32'hF);
            step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
            #2;
            check("resume_an", 32'(an), 32'hD);
            check("resume_b", 32'(b), 32'h3);
         end else begin
            apply(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
         end
      end
      check("en_drop_seen", 32'(dropped), 32'h1);
      check("held_pos", 32'(held_cnt * 8 + held_idx), 32'(2 * 8 + 1));

      // reset mid-frame at cycle 22
      do_reset(16'h1234);
      for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 16'h1234, 4'b0000, 1'b0);
      step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);
      #2;
      check("midrst_an", 32'(an), 32'hF);
      check("midrst_b", 32'(b), 32'h0);
      check("midrst_frame", 32'(frame), 32'h0);
      for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 16'h1234, 4'b0000, 1'b0);

      @(negedge clk);
      #1;
      check("drain", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one `seg_dec` 4-bit-to-7-segment decoder across DIGITS common-anode digits.
- Walks the digits in turn, driving the decoder input `b` and an active-low digit enable `an`.
- Inserts a one-cycle dead time at the start of each digit slot to prevent ghosting.
- Applies per-digit blanking and optional leading-zero suppression.
- Double-buffers the display value, so a displayed frame never tears.
- Sits between the numeric datapath and the external `seg_dec`/segment pads.

Parameters:
- DIGITS, 4, number of digits scanned (≥2).
- DIV, 4, clock cycles per digit slot (≥2); cycle 0 of each slot is dead time.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scan enable; 0 freezes the scan and blanks the display
- data  in  4*DIGITS  display value; nibble i (data[4i+3:4i]) feeds digit i; digit 0 is least significant
- blank_mask  in  DIGITS  1 = force digit i dark
- lz_sup  in  1  leading-zero suppression enable
- b  out  4  nibble to `seg_dec.b`
- an  out  DIGITS  active-low digit enables; at most one bit is low at any time
- frame  out  1  one-cycle pulse on the cycle the shadow registers capture

Behaviour:
- State registers:
  - cnt, range 0..DIV-1.
  - idx, range 0..DIGITS-1.
  - shadow_data (4*DIGITS bits).
  - shadow_mask (DIGITS bits).
  - shadow_lz (1 bit).
- Reset (synchronous; applies at the first rising edge of clk with rst=1, regardless of en):
  - cnt=0, idx=0, shadow_data=0, shadow_mask=0, shadow_lz=0.
  - Outputs: an=all ones, b=0, frame=0.
  - Reset mid-frame aborts the scan; the next cycle shows reset values.
- Advance (en=1, rst=0):
  - If cnt≠DIV-1: cnt++.
  - If cnt=DIV-1: cnt←0 and idx←(idx=DIGITS-1 ? 0 : idx+1).
- Hold (en=0): cnt, idx and the shadows hold; frame=0.
- Capture:
  - Occurs on the edge where en=1, cnt=DIV-1 and idx=DIGITS-1.
  - Loads shadow_data←data, shadow_mask←blank_mask, shadow_lz←lz_sup.
  - The new values apply from the next cycle (idx=0 of the next frame).
  - frame is a registered output: it is 1 in the cycle after the capture edge (the first cycle of the new frame) and 0 otherwise.
- Frame length: DIGITS*DIV cycles.
- After reset, the first frame displays the shadow's reset value (0).
- b (combinational from registers): shadow_data nibble idx. It is driven even when the digit is dark.
- Digit dark when any of these holds:
  - en=0;
  - cnt=0 (dead time);
  - shadow_mask[idx]=1;
  - LZ condition: shadow_lz=1 and idx≠0 and every nibble j≥idx of shadow_data is 0.
- an: all ones when the digit is dark; otherwise only bit idx is 0.
- Digit 0 is never LZ-suppressed. A value of 0 with lz_sup shows a single "0".
- data and blank_mask changes between captures have no visible effect until the next capture.
- en toggling resumes from the held cnt/idx, with no skipped or repeated slot cycles.
- Output latency: `an`/`b` reflect register state in the same cycle (no extra pipeline stage).

Test Plan (DIGITS=4, DIV=4; cycle 0 = first edge after rst deasserts):
- Reset: hold rst=1 with en=1 and data=16'hFFFF → an=4'b1111, b=0, frame=0 throughout. One cycle after release, cnt=0, idx=0.
- Basic scan: data=16'h1234, en=1.
  - Capture edge at cycle 15; frame=1 in cycle 16.
  - Cycle 16: an=1111, b=4.
  - Cycles 17–19: an=1110, b=4.
  - Cycle 20: an=1111, b=3.
  - Cycles 21–23: an=1101, b=3.
  - Then 2 on an=1011 and 1 on an=0111.
  - Pattern repeats every 16 cycles.
- LZ suppression: lz_sup=1.
  - data=16'h0050: only an=1110 (b=0) and an=1101 (b=5) ever go active.
  - data=16'h0000: only an=1110 (b=0).
  - data=16'h0050 with lz_sup=0: all four digits are driven.
- Tear-free update: change data from 16'h1234 to 16'hABCD at cycle 20 → digits 2 and 3 still show 2 and 1 in that frame; A–D appear from cycle 32.
- Blank and en:
  - blank_mask=4'b0100: digit 2 is never active.
  - Drop en for 5 cycles at cnt=2: an=1111 and state frozen.
  - Restore en: resumes at cnt=2 with the same idx and the same b.
- Reset mid-frame: assert rst at cycle 22 → next cycle an=1111, b=0, frame=0. After release, scanning restarts at idx 0 showing 0s until the next capture.
